// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 64-bit RISC-V core: writeback bypass into the
// captured operands, load-use bubble insertion, branch flush and debug counters.
module id_ex_stage #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_regwrite,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int unsigned CTRL_MEMREAD = 1;

  logic              r_ex_valid;
  logic [XLEN-1:0]   r_ex_pc;
  logic [XLEN-1:0]   r_ex_imm;
  logic [RA_W-1:0]   r_ex_rs1;
  logic [RA_W-1:0]   r_ex_rs2;
  logic [RA_W-1:0]   r_ex_rd;
  logic [XLEN-1:0]   r_ex_rs1_data;
  logic [XLEN-1:0]   r_ex_rs2_data;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic [XLEN-1:0]   w_rs1_op;
  logic [XLEN-1:0]   w_rs2_op;
  logic              w_hazard;
  logic              w_bubble;

  // Operand select: x0 reads zero, a same-cycle writeback overrides the stale RF read
  always_comb begin
    w_rs1_op = id_rs1_data;
    w_rs2_op = id_rs2_data;
    if (id_rs1 == '0)
      w_rs1_op = '0;
    else if (wb_regwrite && (wb_rd == id_rs1))
      w_rs1_op = wb_data;
    if (id_rs2 == '0)
      w_rs2_op = '0;
    else if (wb_regwrite && (wb_rd == id_rs2))
      w_rs2_op = wb_data;
  end

  assign w_hazard = r_ex_valid && r_ex_ctrl[CTRL_MEMREAD] && (r_ex_rd != '0) && id_valid &&
                    ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
  assign w_bubble = flush || w_hazard;
  assign stall    = w_hazard && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_imm      <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_ctrl     <= '0;
    end else if (w_bubble) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_imm      <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_ctrl     <= '0;
    end else begin
      r_ex_valid    <= id_valid;
      r_ex_pc       <= id_pc;
      r_ex_imm      <= id_imm;
      r_ex_rs1      <= id_rs1;
      r_ex_rs2      <= id_rs2;
      r_ex_rd       <= id_rd;
      r_ex_rs1_data <= w_rs1_op;
      r_ex_rs2_data <= w_rs2_op;
      r_ex_ctrl     <= id_valid ? id_ctrl : '0;
    end
  end

  // Saturating debug counters; a flush only counts when it squashes a real instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush && id_valid && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_pc       = r_ex_pc;
  assign ex_imm      = r_ex_imm;
  assign ex_rs1      = r_ex_rs1;
  assign ex_rs2      = r_ex_rs2;
  assign ex_rd       = r_ex_rd;
  assign ex_rs1_data = r_ex_rs1_data;
  assign ex_rs2_data = r_ex_rs2_data;
  assign ex_ctrl     = r_ex_ctrl;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a second instance with 2-bit counters
// exercises counter saturation.
module tb_id_ex_stage;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned RA_W   = 5;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned SAT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc, id_imm, id_rs1_data, id_rs2_data, wb_data;
  logic [RA_W-1:0]   id_rs1, id_rs2, id_rd, wb_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              wb_regwrite, flush;

  logic              stall, ex_valid;
  logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [RA_W-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  logic              s_stall, s_ex_valid;
  logic [XLEN-1:0]   s_ex_pc, s_ex_imm, s_ex_rs1_data, s_ex_rs2_data;
  logic [RA_W-1:0]   s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [CTRL_W-1:0] s_ex_ctrl;
  logic [SAT_W-1:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_ctrl(id_ctrl), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W), .CTRL_W(CTRL_W), .CNT_W(SAT_W)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_ctrl(id_ctrl), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush), .stall(s_stall),
    .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1),
    .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_rs1_data(s_ex_rs1_data),
    .ex_rs2_data(s_ex_rs2_data), .ex_ctrl(s_ex_ctrl), .stall_cnt(s_stall_cnt),
    .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                          input logic [63:0] d1, input logic [4:0] rs2, input logic [63:0] d2,
                          input logic [4:0] rd, input logic [7:0] ctrl);
    id_valid    = v;
    id_pc       = pc;
    id_imm      = pc + 64'h4;
    id_rs1      = rs1;
    id_rs1_data = d1;
    id_rs2      = rs2;
    id_rs2_data = d2;
    id_rd       = rd;
    id_ctrl     = ctrl;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0;
    drive_id(1'b0, 64'h0, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 8'h00);
    #12;
    check("rst_ex_valid", 64'(ex_valid), 64'h0);
    check("rst_stall", 64'(stall), 64'h0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'h0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'h0);
    rst_n = 1'b1;

    // Writeback bypass into rs1, rs2 from register file
    drive_id(1'b1, 64'h100, 5'd5, 64'h11, 5'd6, 64'h22, 5'd3, 8'h01);
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 64'h99;
    tick();
    check("byp_rs1_data", ex_rs1_data, 64'h99);
    check("byp_rs2_data", ex_rs2_data, 64'h22);
    check("byp_ex_valid", 64'(ex_valid), 64'h1);
    check("byp_ex_pc", ex_pc, 64'h100);
    check("byp_ex_imm", ex_imm, 64'h104);
    check("byp_ex_ctrl", 64'(ex_ctrl), 64'h01);
    check("byp_ex_rd", 64'(ex_rd), 64'h3);

    // x0 never bypassed; rs2 now bypassed
    drive_id(1'b1, 64'h104, 5'd0, 64'h11, 5'd5, 64'h33, 5'd4, 8'h01);
    tick();
    check("x0_rs1_data", ex_rs1_data, 64'h0);
    check("byp_rs2_hit", ex_rs2_data, 64'h99);
    wb_regwrite = 1'b0;

    // Load-use: ld x7 then add x8, x1, x7
    drive_id(1'b1, 64'h108, 5'd2, 64'h1000, 5'd0, 64'h0, 5'd7, 8'h0B);
    tick();
    drive_id(1'b1, 64'h10C, 5'd1, 64'h5, 5'd7, 64'h6, 5'd8, 8'h81);
    #1;
    check("lu_stall", 64'(stall), 64'h1);
    tick();
    check("lu_bubble_valid", 64'(ex_valid), 64'h0);
    check("lu_bubble_ctrl", 64'(ex_ctrl), 64'h00);
    check("lu_bubble_pc", ex_pc, 64'h0);
    check("lu_stall_cnt", 64'(stall_cnt), 64'h1);
    check("lu_stall_clear", 64'(stall), 64'h0);
    tick();
    check("lu_add_valid", 64'(ex_valid), 64'h1);
    check("lu_add_pc", ex_pc, 64'h10C);
    check("lu_add_ctrl", 64'(ex_ctrl), 64'h81);
    check("lu_add_rs2", 64'(ex_rs2), 64'h7);
    check("lu_add_rs2_data", ex_rs2_data, 64'h6);

    // Load into x0 never creates a hazard
    drive_id(1'b1, 64'h110, 5'd3, 64'h0, 5'd0, 64'h0, 5'd0, 8'h0B);
    tick();
    drive_id(1'b1, 64'h114, 5'd0, 64'h0, 5'd0, 64'h0, 5'd9, 8'h01);
    #1;
    check("x0_no_stall", 64'(stall), 64'h0);
    tick();
    check("x0_ex_pc", ex_pc, 64'h114);
    check("x0_ex_valid", 64'(ex_valid), 64'h1);
    check("x0_stall_cnt", 64'(stall_cnt), 64'h1);

    // Flush beats a simultaneous load-use hazard
    drive_id(1'b1, 64'h118, 5'd1, 64'h0, 5'd0, 64'h0, 5'd9, 8'h0B);
    tick();
    drive_id(1'b1, 64'h11C, 5'd9, 64'h1, 5'd2, 64'h2, 5'd10, 8'h01);
    flush = 1'b1;
    #1;
    check("fl_stall", 64'(stall), 64'h0);
    tick();
    check("fl_bubble_valid", 64'(ex_valid), 64'h0);
    check("fl_bubble_ctrl", 64'(ex_ctrl), 64'h00);
    check("fl_flush_cnt", 64'(flush_cnt), 64'h1);
    check("fl_stall_cnt", 64'(stall_cnt), 64'h1);

    // Flush of an empty ID slot is not counted
    drive_id(1'b0, 64'h120, 5'd1, 64'h0, 5'd2, 64'h0, 5'd3, 8'h01);
    tick();
    check("fl_invalid_cnt", 64'(flush_cnt), 64'h1);
    flush = 1'b0;

    // Invalid ID loads a non-valid, zero-control slot
    drive_id(1'b0, 64'h124, 5'd1, 64'h0, 5'd2, 64'h0, 5'd3, 8'h01);
    tick();
    check("inv_ex_valid", 64'(ex_valid), 64'h0);
    check("inv_ex_ctrl", 64'(ex_ctrl), 64'h00);

    // Asynchronous reset with a real instruction in EX
    drive_id(1'b1, 64'h128, 5'd1, 64'hAA, 5'd2, 64'hBB, 5'd3, 8'h01);
    tick();
    check("prerst_ex_valid", 64'(ex_valid), 64'h1);
    rst_n = 1'b0;
    #1;
    check("arst_ex_valid", 64'(ex_valid), 64'h0);
    check("arst_ex_pc", ex_pc, 64'h0);
    check("arst_rs1_data", ex_rs1_data, 64'h0);
    check("arst_ex_ctrl", 64'(ex_ctrl), 64'h0);
    check("arst_stall_cnt", 64'(stall_cnt), 64'h0);
    check("arst_flush_cnt", 64'(flush_cnt), 64'h0);
    #1;
    rst_n = 1'b1;
    drive_id(1'b1, 64'h40, 5'd1, 64'h0, 5'd2, 64'h0, 5'd3, 8'h01);
    tick();
    check("postrst_ex_pc", ex_pc, 64'h40);
    check("postrst_ex_valid", 64'(ex_valid), 64'h1);

    // ld x7,0(x7) repeated: stalls every other edge
    drive_id(1'b1, 64'h200, 5'd7, 64'h0, 5'd0, 64'h0, 5'd7, 8'h0B);
    repeat (6) tick();
    check("sat_main_cnt3", 64'(stall_cnt), 64'h3);
    check("sat_small_cnt3", 64'(s_stall_cnt), 64'h3);
    repeat (4) tick();
    check("sat_main_cnt5", 64'(stall_cnt), 64'h5);
    check("sat_small_hold", 64'(s_stall_cnt), 64'h3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the 64-bit pipelined RISC-V core. It sits directly downstream of the register file:
- captures both read operands plus the decoded fields and control of the instruction in ID;
- bypasses a same-cycle writeback into those operands;
- detects load-use hazards and inserts bubbles;
- honours branch flushes from EX;
- keeps saturating stall and flush counters for debug.

## Interface
- XLEN, 64, datapath width
- RA_W, 5, register index width
- CTRL_W, 8, packed control width. Bit map:
  - [0] RegWrite, [1] MemRead, [2] MemWrite, [3] MemtoReg
  - [4] ALUSrc, [5] Branch, [7:6] ALUOp
- CNT_W, 32, performance counter width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_imm  in  XLEN  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  RA_W  register indices
- id_rs1_data, id_rs2_data  in  XLEN  register file read data
- id_ctrl  in  CTRL_W  decoded control
- wb_regwrite  in  1  writeback write enable this cycle
- wb_rd  in  RA_W  writeback destination
- wb_data  in  XLEN  writeback value
- flush  in  1  branch taken in EX; squash instruction in ID
- stall  out  1  hold PC and IF/ID register
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_imm  out  XLEN  latched PC / immediate
- ex_rs1, ex_rs2, ex_rd  out  RA_W  latched indices
- ex_rs1_data, ex_rs2_data  out  XLEN  latched operands
- ex_ctrl  out  CTRL_W  latched control; all zero for a bubble
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Operand select, per source s ∈ {rs1, rs2}:
  - id_s == 0 → 0;
  - else wb_regwrite && wb_rd == id_s → wb_data;
  - else id_s_data.
  - This covers the register file updating on the same edge that ID reads it.
- Load-use hazard (combinational), true when all hold:
  - ex_valid, ex_ctrl[1], ex_rd != 0, id_valid;
  - ex_rd == id_rs1 || ex_rd == id_rs2 (both checked regardless of instruction format).
- stall = hazard && !flush.
- Next-state priority at each rising edge:
  1. flush → load bubble: ex_valid=0, ex_ctrl=0, other ex_* fields 0.
  2. hazard → load bubble (same values). ID is held upstream by stall.
  3. else → load ID: ex_valid=id_valid; ex_ctrl=id_ctrl if id_valid else 0; remaining fields from ID and operand select.
- No separate state register. The bubble in EX clears the hazard on the next cycle, so every load-use stall lasts exactly 1 cycle.
- Counters:
  - stall_cnt +1 on each edge where stall=1.
  - flush_cnt +1 on each edge where flush=1 && id_valid.
  - Both saturate at all-ones and never wrap.
- Flush with simultaneous hazard: flush wins, stall stays 0, only flush_cnt increments.
- Bypass also applies to the operands captured on an edge that loads ID.

## Timing
- Reset (rst_n low, asynchronous): every ex_* output and both counters go to 0; ex_valid=0.
  - stall then evaluates to 0, because ex_valid=0.
  - Reset mid-stall or mid-flush discards the EX instruction. The first edge after release loads ID normally.
- Latency: ID to EX is 1 cycle. stall, and the bypass, are combinational from current inputs and current ex_* state. There is no registered path.
- All ex_* outputs change only on rising clk or on reset assertion.

## Test plan
- Reset: drive rst_n=0 mid-run with ex_valid=1 → all outputs 0 immediately, with no clock edge. First edge after release with id_valid=1, id_pc=0x40 → ex_pc=0x40, ex_valid=1.
- Bypass: id_rs1=5, id_rs1_data=0x11, wb_regwrite=1, wb_rd=5, wb_data=0x99 → ex_rs1_data=0x99. Same stimulus with id_rs1=0 → 0.
- Load-use: EX holds ld x7 (ex_ctrl[1]=1, ex_rd=7), ID holds add rs2=7 →
  - stall=1 for exactly 1 cycle;
  - next edge: ex_valid=0, ex_ctrl=0x00, stall_cnt=1;
  - following edge: add enters EX.
- No hazard on x0: load with ex_rd=0 and ID rs1=0 → stall=0 and no bubble.
- Flush priority: flush=1 together with a load-use hazard → stall=0, next edge bubble, flush_cnt=1, stall_cnt=0.
- Saturation: preload stall_cnt=0xFFFFFFFF by forcing, then another stall → stall_cnt remains 0xFFFFFFFF.
